fetch_control: RTL and testbench
================================

# fetch_control

Sequencing controller for the fetch stage and the fetch/decode pipeline register. Owns the PC, drives the instruction-memory read request, and generates the write/stall/flush controls for the fetch/decode register. Resolves branch/jump redirects, hazard stalls and halt against an instruction-memory request that cannot be aborted mid-flight.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CLK  in  1  single clock; all state updates on rising edge.
- nRST  in  1  asynchronous reset, active-low.
- ihit  in  1  instruction memory returned data for imemaddr this cycle.
- hazard_stall  in  1  decode/hazard unit requests the fetch/decode register hold.
- redirect  in  1  later stage resolved a taken branch/jump; fetch must restart at redirect_pc.
- redirect_pc  in  32  redirect target; bits [1:0] ignored and treated as 00.
- halt  in  1  halt instruction committed; fetching stops permanently until reset.
- imemREN  out  1  instruction read request.
- imemaddr  out  32  current PC, bits [1:0] always 00.
- next_memaddr  out  32  imemaddr + 4, modulo 2^32.
- fd_ihit  out  1  fetch/decode register captures imemload/imemaddr/next_memaddr this edge.
- fd_stall  out  1  fetch/decode register holds contents.
- fd_flush  out  1  fetch/decode register clears to NOP; has priority over fd_ihit/fd_stall in that register.
- halted  out  1  controller in HALT state.
- fetch_count  out  32  number of instructions accepted into the fetch/decode register.

## Operation
- States: FETCH, DRAIN, HALT. Reset state FETCH.
- Registers: pc, pending_pc, state, fetch_count.
- Reset (nRST low, asynchronous): pc=RESET_PC, pending_pc=0, state=FETCH, fetch_count=0. Resulting outputs: imemREN=1, imemaddr=RESET_PC, next_memaddr=RESET_PC+4, fd_ihit=0, fd_stall=0, fd_flush=0, halted=0.
- Input priority each cycle: halt > redirect > hazard_stall > ihit.
- FETCH: imemREN=1, imemaddr=pc.
  - halt: fd_flush=1, fd_ihit=0; -> HALT.
  - redirect & ihit: fd_flush=1, fd_ihit=0; pc<=redirect_pc; stay FETCH.
  - redirect & !ihit: fd_flush=1; pending_pc<=redirect_pc; -> DRAIN (outstanding request must complete at unchanged address).
  - hazard_stall (no redirect): fd_stall=1, fd_ihit=0; pc holds regardless of ihit (instruction is re-fetched).
  - ihit only: fd_ihit=1; pc<=pc+4; fetch_count<=fetch_count+1.
  - none: all fd controls 0; pc holds.
- DRAIN: imemREN=1, imemaddr=pc (old address held); fd_flush=1 every cycle; fd_ihit=0.
  - halt: -> HALT.
  - redirect: pending_pc<=redirect_pc (latest redirect wins).
  - ihit: data discarded; pc<=(redirect this cycle ? redirect_pc : pending_pc); -> FETCH.
  - hazard_stall ignored in DRAIN.
- HALT: imemREN=0, fd_stall=1, fd_flush=0, fd_ihit=0, halted=1; pc, fetch_count frozen; all inputs ignored; exit only by reset. Memory side tolerates withdrawal of an outstanding read.
- Arithmetic: pc+4 and fetch_count+1 wrap modulo 2^32, no saturation.
- fd_ihit, fd_stall, fd_flush mutually exclusive in all states.

## Timing
- imemaddr, next_memaddr, imemREN, halted: functions of registered state only (no input-to-output path).
- fd_ihit, fd_stall, fd_flush: combinational from state and same-cycle inputs; the fetch/decode register samples them on the same edge.
- Fetch latency: ihit in cycle N -> instruction in fetch/decode register and new imemaddr from cycle N+1.
- Redirect with ihit: new PC presented next cycle (1-cycle penalty plus flushed slot).
- Redirect without ihit: new PC presented the cycle after the draining ihit.
- nRST assertion mid-DRAIN or mid-HALT: immediate return to reset values; pending_pc discarded.

## Test plan
- Reset, ihit held high 4 cycles -> imemaddr 0,4,8,12; fd_ihit=1 each cycle; fetch_count=4; RESET_PC=0x100 variant starts at 0x100.
- ihit=1 with hazard_stall=1 for 2 cycles at pc=0x8 -> fd_stall=1, fd_ihit=0, imemaddr stays 0x8, fetch_count unchanged; release -> fetch resumes at 0x8.
- redirect=1, redirect_pc=0x40, ihit=1 at pc=0x10 -> fd_flush=1 that cycle, imemaddr=0x40 next cycle, state FETCH.
- redirect to 0x40 with ihit=0 at pc=0x10, then redirect to 0x80 one cycle later, ihit 3 cycles after -> imemaddr held 0x10 and fd_flush=1 throughout DRAIN, then imemaddr=0x80; no instruction from 0x10 captured.
- halt=1 at pc=0x20 -> fd_flush=1 that cycle, then imemREN=0, halted=1, fd_stall=1; later ihit/redirect ignored; nRST low -> imemaddr=RESET_PC, halted=0.
- pc=0xFFFF_FFFC with ihit -> next imemaddr 0x0000_0000; fetch_count preloaded near 0xFFFF_FFFF wraps to 0.

Source files
------------

// File: rtl/fetch_control.sv
// Fetch-stage sequencer: owns the PC, issues instruction reads and steers the
// fetch/decode register through redirects, hazard stalls and halt.
module fetch_control #(
    parameter logic [31:0] RESET_PC          = 32'h0000_0000,
    parameter logic [31:0] RESET_FETCH_COUNT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        hazard_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic [31:0] next_memaddr,
    output logic        fd_ihit,
    output logic        fd_stall,
    output logic        fd_flush,
    output logic        halted,
    output logic [31:0] fetch_count
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pending_pc_q, pending_pc_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] target_pc;

    assign target_pc = redirect_pc & 32'hFFFF_FFFC;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pending_pc_d  = pending_pc_q;
        fetch_count_d = fetch_count_q;
        fd_ihit       = 1'b0;
        fd_stall      = 1'b0;
        fd_flush      = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (halt) begin
                    fd_flush = 1'b1;
                    state_d  = ST_HALT;
                end else if (redirect) begin
                    fd_flush = 1'b1;
                    if (ihit) begin
                        pc_d = target_pc;
                    end else begin
                        // The in-flight read cannot be cancelled; park the target until it lands.
                        pending_pc_d = target_pc;
                        state_d      = ST_DRAIN;
                    end
                end else if (hazard_stall) begin
                    fd_stall = 1'b1;
                end else if (ihit) begin
                    fd_ihit       = 1'b1;
                    pc_d          = pc_q + 32'd4;
                    fetch_count_d = fetch_count_q + 32'd1;
                end
            end

            ST_DRAIN: begin
                fd_flush = 1'b1;
                if (halt) begin
                    state_d = ST_HALT;
                end else begin
                    if (redirect) begin
                        pending_pc_d = target_pc;
                    end
                    if (ihit) begin
                        pc_d    = redirect ? target_pc : pending_pc_q;
                        state_d = ST_FETCH;
                    end
                end
            end

            ST_HALT: begin
                fd_stall = 1'b1;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC_ALIGNED;
            pending_pc_q  <= 32'h0000_0000;
            fetch_count_q <= RESET_FETCH_COUNT;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pending_pc_q  <= pending_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imemREN      = (state_q != ST_HALT);
    assign halted       = (state_q == ST_HALT);
    assign imemaddr     = pc_q;
    assign next_memaddr = pc_q + 32'd4;
    assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_fetch_control.sv
// Directed bench for fetch_control: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the selected DUT.
module tb_fetch_control;

    logic        CLK;
    logic        nRST;
    logic        ihit;
    logic        hazard_stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;

    logic        ren_a, fi_a, fs_a, ff_a, hl_a;
    logic [31:0] addr_a, nxt_a, cnt_a;
    logic        ren_b, fi_b, fs_b, ff_b, hl_b;
    logic [31:0] addr_b, nxt_b, cnt_b;

    fetch_control dut_a (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .hazard_stall(hazard_stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .imemREN(ren_a), .imemaddr(addr_a), .next_memaddr(nxt_a),
        .fd_ihit(fi_a), .fd_stall(fs_a), .fd_flush(ff_a), .halted(hl_a),
        .fetch_count(cnt_a)
    );

    fetch_control #(
        .RESET_PC(32'h0000_0100),
        .RESET_FETCH_COUNT(32'hFFFF_FFFE)
    ) dut_b (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .hazard_stall(hazard_stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .imemREN(ren_b), .imemaddr(addr_b), .next_memaddr(nxt_b),
        .fd_ihit(fi_b), .fd_stall(fs_b), .fd_flush(ff_b), .halted(hl_b),
        .fetch_count(cnt_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Input vector bits: {halt, redirect, hazard_stall, ihit}
    localparam logic [3:0] I_NONE = 4'b0000;
    localparam logic [3:0] I_IH   = 4'b0001;
    localparam logic [3:0] I_HZ   = 4'b0010;
    localparam logic [3:0] I_HZIH = 4'b0011;
    localparam logic [3:0] I_RD   = 4'b0100;
    localparam logic [3:0] I_RDIH = 4'b0101;
    localparam logic [3:0] I_HL   = 4'b1000;
    localparam logic [3:0] I_HLIH = 4'b1001;
    localparam logic [3:0] I_ALL  = 4'b1101;

    // Expected control bits: {imemREN, fd_ihit, fd_stall, fd_flush, halted}
    localparam logic [4:0] C_IDLE = 5'b10000;
    localparam logic [4:0] C_HIT  = 5'b11000;
    localparam logic [4:0] C_STL  = 5'b10100;
    localparam logic [4:0] C_FLS  = 5'b10010;
    localparam logic [4:0] C_HLT  = 5'b00101;

    typedef struct {
        int          sel;
        int          id;
        logic [4:0]  ctl;
        logic [31:0] addr;
        logic [31:0] nxt;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_compared = 0;
    int   n_mismatch = 0;
    int   vec_id     = 0;

    task automatic push_exp(input int sel, input logic [4:0] ctl,
                            input logic [31:0] addr, input logic [31:0] nxt,
                            input logic [31:0] cnt);
        exp_t e;
        e.sel  = sel;
        e.id   = vec_id;
        e.ctl  = ctl;
        e.addr = addr;
        e.nxt  = nxt;
        e.cnt  = cnt;
        exp_q.push_back(e);
        vec_id++;
    endtask

    // Called at posedge+1; leaves at the next posedge+1.
    task automatic step(input int sel, input logic [3:0] in_v, input logic [31:0] rpc,
                        input logic [4:0] ctl, input logic [31:0] addr,
                        input logic [31:0] nxt, input logic [31:0] cnt);
        halt         = in_v[3];
        redirect     = in_v[2];
        hazard_stall = in_v[1];
        ihit         = in_v[0];
        redirect_pc  = rpc;
        push_exp(sel, ctl, addr, nxt, cnt);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input int sel, input logic [31:0] addr, input logic [31:0] cnt);
        halt         = 1'b0;
        redirect     = 1'b0;
        hazard_stall = 1'b0;
        ihit         = 1'b0;
        redirect_pc  = 32'h0;
        nRST         = 1'b0;
        push_exp(sel, C_IDLE, addr, addr + 32'd4, cnt);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [4:0]  a_ctl;
            logic [31:0] a_addr, a_nxt, a_cnt;
            e = exp_q.pop_front();
            if (e.sel == 1) begin
                a_ctl = {ren_b, fi_b, fs_b, ff_b, hl_b};
                a_addr = addr_b; a_nxt = nxt_b; a_cnt = cnt_b;
            end else begin
                a_ctl = {ren_a, fi_a, fs_a, ff_a, hl_a};
                a_addr = addr_a; a_nxt = nxt_a; a_cnt = cnt_a;
            end
            n_compared++;
            if (a_ctl !== e.ctl || a_addr !== e.addr || a_nxt !== e.nxt || a_cnt !== e.cnt) begin
                n_mismatch++;
                $display("FAIL vec%0d dut%0d: got ctl=%b addr=%h nxt=%h cnt=%h, want ctl=%b addr=%h nxt=%h cnt=%h",
                         e.id, e.sel, a_ctl, a_addr, a_nxt, a_cnt, e.ctl, e.addr, e.nxt, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        nRST = 1'b0; halt = 1'b0; redirect = 1'b0; hazard_stall = 1'b0;
        ihit = 1'b0; redirect_pc = 32'h0;
        @(posedge CLK);
        #1;

        do_reset(0, 32'h0, 32'h0);

        // Straight-line fetch
        step(0, I_IH,   32'h0, C_HIT,  32'h0000_0000, 32'h0000_0004, 32'd0);
        step(0, I_IH,   32'h0, C_HIT,  32'h0000_0004, 32'h0000_0008, 32'd1);
        step(0, I_IH,   32'h0, C_HIT,  32'h0000_0008, 32'h0000_000C, 32'd2);
        step(0, I_IH,   32'h0, C_HIT,  32'h0000_000C, 32'h0000_0010, 32'd3);
        step(0, I_NONE, 32'h0, C_IDLE, 32'h0000_0010, 32'h0000_0014, 32'd4);

        // Move to 0x8 and stall with ihit present
        step(0, I_RDIH, 32'h8, C_FLS,  32'h0000_0010, 32'h0000_0014, 32'd4);
        step(0, I_HZIH, 32'h0, C_STL,  32'h0000_0008, 32'h0000_000C, 32'd4);
        step(0, I_HZIH, 32'h0, C_STL,  32'h0000_0008, 32'h0000_000C, 32'd4);
        step(0, I_IH,   32'h0, C_HIT,  32'h0000_0008, 32'h0000_000C, 32'd4);
        step(0, I_IH,   32'h0, C_HIT,  32'h0000_000C, 32'h0000_0010, 32'd5);

        // Redirect with ihit at 0x10; low target bits dropped
        step(0, I_RDIH, 32'h43, C_FLS, 32'h0000_0010, 32'h0000_0014, 32'd6);
        step(0, I_NONE, 32'h0, C_IDLE, 32'h0000_0040, 32'h0000_0044, 32'd6);

        // Back to 0x10, then redirect without ihit and a later redirect in DRAIN
        step(0, I_RDIH, 32'h10, C_FLS, 32'h0000_0040, 32'h0000_0044, 32'd6);
        step(0, I_RD,   32'h40, C_FLS, 32'h0000_0010, 32'h0000_0014, 32'd6);
        step(0, I_RD,   32'h80, C_FLS, 32'h0000_0010, 32'h0000_0014, 32'd6);
        step(0, I_HZ,   32'h0, C_FLS,  32'h0000_0010, 32'h0000_0014, 32'd6);
        step(0, I_NONE, 32'h0, C_FLS,  32'h0000_0010, 32'h0000_0014, 32'd6);
        step(0, I_IH,   32'h0, C_FLS,  32'h0000_0010, 32'h0000_0014, 32'd6);
        step(0, I_IH,   32'h0, C_HIT,  32'h0000_0080, 32'h0000_0084, 32'd6);

        // Redirect arriving together with the draining ihit wins
        step(0, I_RD,   32'h200, C_FLS, 32'h0000_0084, 32'h0000_0088, 32'd7);
        step(0, I_RDIH, 32'h300, C_FLS, 32'h0000_0084, 32'h0000_0088, 32'd7);
        step(0, I_NONE, 32'h0,   C_IDLE, 32'h0000_0300, 32'h0000_0304, 32'd7);

        // Halt at 0x20 beats redirect/ihit, then everything is ignored
        step(0, I_RDIH, 32'h20,  C_FLS, 32'h0000_0300, 32'h0000_0304, 32'd7);
        step(0, I_ALL,  32'h500, C_FLS, 32'h0000_0020, 32'h0000_0024, 32'd7);
        step(0, I_RDIH, 32'h60,  C_HLT, 32'h0000_0020, 32'h0000_0024, 32'd7);
        step(0, I_HZIH, 32'h0,   C_HLT, 32'h0000_0020, 32'h0000_0024, 32'd7);
        step(0, I_HL,   32'h0,   C_HLT, 32'h0000_0020, 32'h0000_0024, 32'd7);

        // Reset out of HALT
        do_reset(0, 32'h0, 32'h0);
        step(0, I_IH,   32'h0, C_HIT,  32'h0000_0000, 32'h0000_0004, 32'd0);

        // PC wrap at top of address space
        step(0, I_RDIH, 32'hFFFF_FFFC, C_FLS, 32'h0000_0004, 32'h0000_0008, 32'd1);
        step(0, I_IH,   32'h0, C_HIT,  32'hFFFF_FFFC, 32'h0000_0000, 32'd1);
        step(0, I_NONE, 32'h0, C_IDLE, 32'h0000_0000, 32'h0000_0004, 32'd2);

        // Reset mid-DRAIN discards the pending target
        step(0, I_RD,   32'h40, C_FLS, 32'h0000_0000, 32'h0000_0004, 32'd2);
        do_reset(0, 32'h0, 32'h0);
        step(0, I_IH,   32'h0, C_HIT,  32'h0000_0000, 32'h0000_0004, 32'd0);

        // Halt taken from DRAIN
        step(0, I_RD,   32'h40, C_FLS, 32'h0000_0004, 32'h0000_0008, 32'd1);
        step(0, I_HLIH, 32'h0,  C_FLS, 32'h0000_0004, 32'h0000_0008, 32'd1);
        step(0, I_NONE, 32'h0,  C_HLT, 32'h0000_0004, 32'h0000_0008, 32'd1);

        // Non-default reset PC and fetch counter wrap
        do_reset(1, 32'h0000_0100, 32'hFFFF_FFFE);
        step(1, I_IH,   32'h0, C_HIT,  32'h0000_0100, 32'h0000_0104, 32'hFFFF_FFFE);
        step(1, I_IH,   32'h0, C_HIT,  32'h0000_0104, 32'h0000_0108, 32'hFFFF_FFFF);
        step(1, I_IH,   32'h0, C_HIT,  32'h0000_0108, 32'h0000_010C, 32'h0000_0000);
        step(1, I_IH,   32'h0, C_HIT,  32'h0000_010C, 32'h0000_0110, 32'h0000_0001);
        step(1, I_NONE, 32'h0, C_IDLE, 32'h0000_0110, 32'h0000_0114, 32'h0000_0002);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(posedge CLK);
        end
        if (exp_q.size() > 0) begin
            n_mismatch++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
